// File: rtl/adsr_pkg.sv
// ---------------------------------------------------------------------------
// adsr_pkg
// Shared types and constants for the ADSR envelope generator.
//   stage_t     : envelope stage encoding exported on the stage output
//   DEF_AMP_W   : default amplitude width
//   DEF_AMP_MAX : full-scale amplitude for the default width
//   RATE_W      : width of the attack/decay/release rate inputs
// ---------------------------------------------------------------------------
package adsr_pkg;

  localparam int DEF_AMP_W   = 10;
  localparam int DEF_AMP_MAX = (1 << DEF_AMP_W) - 1;
  localparam int RATE_W      = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } stage_t;

endpackage

// File: rtl/adsr_envelope_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Free-running divider producing a one-clock tick every DIV clocks.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (counter restarts at 0)
//   tick  : high for one clock when the count reaches DIV-1
// ---------------------------------------------------------------------------
module tick_prescaler #(
  parameter int DIV = 5000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// ---------------------------------------------------------------------------
// adsr_envelope
// Converts a note gate into a programmable attack/decay/sustain/release
// amplitude contour. The amplitude only moves on prescaler ticks; gate edges
// change stage immediately.
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   gate         : note held (level, edge-detected internally)
//   attack_rate  : increment per tick in ATTACK (0 = instant)
//   decay_rate   : decrement per tick in DECAY (0 = instant)
//   sustain_lvl  : sustain target amplitude
//   release_rate : decrement per tick in RELEASE (0 = instant)
//   amp_out      : registered envelope amplitude
//   stage        : current stage (IDLE=0 .. RELEASE=4)
//   busy         : high whenever stage != IDLE
// ---------------------------------------------------------------------------
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int CLKSPEED = 50_000_000,
  parameter int TICK_HZ  = 10_000,
  parameter int AMP_W    = DEF_AMP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gate,
  input  logic [RATE_W-1:0] attack_rate,
  input  logic [RATE_W-1:0] decay_rate,
  input  logic [AMP_W-1:0]  sustain_lvl,
  input  logic [RATE_W-1:0] release_rate,
  output logic [AMP_W-1:0]  amp_out,
  output logic [2:0]        stage,
  output logic              busy
);

  localparam int             DIV     = CLKSPEED / TICK_HZ;
  localparam logic [AMP_W-1:0] AMP_MAX = '1;

  logic             tick;
  logic             gate_q;
  logic             rise;
  logic             fall;
  stage_t           state_q, state_d;
  logic [AMP_W-1:0] amp_q, amp_d;

  logic [AMP_W:0]   attackSum;
  logic signed [AMP_W+1:0] decayDiff;
  logic [AMP_W-1:0] releaseRateExt;

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;

  // Extra headroom bits so overshoot past full scale or below zero is visible.
  assign attackSum      = {1'b0, amp_q} + {{(AMP_W + 1 - RATE_W){1'b0}}, attack_rate};
  assign decayDiff      = $signed({2'b00, amp_q})
                        - $signed({{(AMP_W + 2 - RATE_W){1'b0}}, decay_rate});
  assign releaseRateExt = {{(AMP_W - RATE_W){1'b0}}, release_rate};

  // Gate edges take priority over tick steps; the amplitude is held on the
  // edge cycle so the new stage starts stepping from the current level.
  always_comb begin
    state_d = state_q;
    amp_d   = amp_q;
    if (rise && (state_q == IDLE || state_q == RELEASE)) begin
      state_d = ATTACK;
    end else if (fall && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
      state_d = RELEASE;
    end else if (tick) begin
      case (state_q)
        ATTACK: begin
          if (attack_rate == '0 || attackSum >= {1'b0, AMP_MAX}) begin
            amp_d   = AMP_MAX;
            state_d = DECAY;
          end else begin
            amp_d = attackSum[AMP_W-1:0];
          end
        end
        DECAY: begin
          if (decay_rate == '0 || decayDiff <= $signed({2'b00, sustain_lvl})) begin
            amp_d   = sustain_lvl;
            state_d = SUSTAIN;
          end else begin
            amp_d = decayDiff[AMP_W-1:0];
          end
        end
        SUSTAIN: begin
          amp_d = sustain_lvl;
        end
        RELEASE: begin
          if (release_rate == '0 || amp_q <= releaseRateExt) begin
            amp_d   = '0;
            state_d = IDLE;
          end else begin
            amp_d = amp_q - releaseRateExt;
          end
        end
        default: begin
          amp_d = amp_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q  <= 1'b0;
      state_q <= IDLE;
      amp_q   <= '0;
    end else begin
      gate_q  <= gate;
      state_q <= state_d;
      amp_q   <= amp_d;
    end
  end

  assign amp_out = amp_q;
  assign stage   = state_q;
  assign busy    = (state_q != IDLE);

endmodule
